// File: rtl/mips32_dbg_pkg.sv
// Shared definitions for the mips32 run monitor: FSM states, halt causes and trace entry layout.
package mips32_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] HC_NONE     = 2'd0;
  localparam logic [1:0] HC_HALTWORD = 2'd1;
  localparam logic [1:0] HC_LOOP     = 2'd2;
  localparam logic [1:0] HC_BUDGET   = 2'd3;

  localparam int TRACE_DATA_W = 32;

  // Trace words are stored as {pc, instruction}, pc in the upper half.
  typedef struct packed {
    logic [TRACE_DATA_W-1:0] pc;
    logic [TRACE_DATA_W-1:0] instruction;
  } trace_entry_t;

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular trace store with saturating fill count and oldest-relative registered read.
module trace_ring_buffer #(
  parameter int ENTRY_W = 64,
  parameter int DEPTH   = 16,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int TC_W   = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [TC_W-1:0]    count,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic               rd_err,
  output logic [ENTRY_W-1:0] rd_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [TC_W-1:0]  FULL     = TC_W'(DEPTH);
  localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]   wr_ptr_reg;
  logic [TC_W-1:0]    count_reg;
  logic [ENTRY_W-1:0] rd_data_reg;
  logic               rd_valid_reg;
  logic               rd_err_reg;
  logic               rd_zero_reg;

  logic [IDX_W-1:0]   oldest;
  logic [IDX_W:0]     sum_raw;
  logic [IDX_W:0]     sum_wrapped;
  logic [IDX_W-1:0]   phys_idx;
  logic               out_of_range;

  // Compare-and-subtract keeps the wrap correct for non-power-of-two depths.
  always_comb begin
    oldest       = (count_reg == FULL) ? wr_ptr_reg : '0;
    sum_raw      = {1'b0, oldest} + {1'b0, rd_idx};
    sum_wrapped  = (sum_raw >= DEPTH_X) ? (sum_raw - DEPTH_X) : sum_raw;
    phys_idx     = IDX_W'(sum_wrapped);
    out_of_range = (TC_W'(rd_idx) >= count_reg);
  end

  // Storage kept free of reset so it maps onto block RAM; out-of-range reads are masked instead.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
    if (rd_req && !out_of_range) rd_data_reg <= mem[phys_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
      rd_zero_reg  <= 1'b1;
    end else begin
      rd_valid_reg <= rd_req;
      if (rd_req) begin
        rd_err_reg  <= out_of_range;
        rd_zero_reg <= out_of_range;
      end
      if (clear) begin
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else if (wr_en) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + IDX_W'(1);
        if (count_reg != FULL) count_reg <= count_reg + TC_W'(1);
      end
    end
  end

  assign count    = count_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_err   = rd_err_reg;
  assign rd_data  = rd_zero_reg ? '0 : rd_data_reg;

endmodule

// File: rtl/mips32_run_monitor.sv
// Run controller for the single-cycle mips32 core: gates execution, detects halt and
// keeps a trace of the last DEPTH retired {pc, instruction} pairs readable after halt.
module mips32_run_monitor
  import mips32_dbg_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 16,
  parameter int                CNT_W       = 16,
  parameter int                MAX_CYCLES  = 1000,
  parameter logic [DATA_W-1:0] HALT_WORD   = '0,
  parameter bit                DETECT_LOOP = 1'b1,
  localparam int               IDX_W       = $clog2(DEPTH),
  localparam int               TC_W        = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instruction,
  output logic              run_enable,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [TC_W-1:0]   trace_count,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_instr
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cycle_count_reg;
  logic [1:0]        halt_cause_reg;
  logic [DATA_W-1:0] prev_pc_reg;
  logic              prev_pc_valid_reg;

  logic [1:0]        cause_now;
  logic              run_start;
  logic              retire;
  logic              rd_fire;
  logic [2*DATA_W-1:0] rd_data;

  assign run_start = start && (state_reg != ST_RUN);
  assign retire    = (state_reg == ST_RUN);
  // A start in the same DONE cycle wins over a read request.
  assign rd_fire   = (state_reg == ST_DONE) && rd_req && !start;

  always_comb begin
    cause_now  = HC_NONE;
    state_next = state_reg;
    if (instruction == HALT_WORD)
      cause_now = HC_HALTWORD;
    else if (DETECT_LOOP && prev_pc_valid_reg && (pc == prev_pc_reg))
      cause_now = HC_LOOP;
    else if (cycle_count_reg == LAST_CYCLE)
      cause_now = HC_BUDGET;

    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (cause_now != HC_NONE) state_next = ST_DONE;
      ST_DONE: if (start) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      cycle_count_reg   <= '0;
      halt_cause_reg    <= HC_NONE;
      prev_pc_reg       <= '0;
      prev_pc_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (run_start) begin
        cycle_count_reg   <= '0;
        halt_cause_reg    <= HC_NONE;
        prev_pc_valid_reg <= 1'b0;
      end else if (retire) begin
        cycle_count_reg   <= cycle_count_reg + CNT_W'(1);
        prev_pc_reg       <= pc;
        prev_pc_valid_reg <= 1'b1;
        if (cause_now != HC_NONE) halt_cause_reg <= cause_now;
      end
    end
  end

  trace_ring_buffer #(
    .ENTRY_W(2 * DATA_W),
    .DEPTH  (DEPTH)
  ) u_trace (
    .clock   (clock),
    .reset   (reset),
    .clear   (run_start),
    .wr_en   (retire),
    .wr_data ({pc, instruction}),
    .count   (trace_count),
    .rd_req  (rd_fire),
    .rd_idx  (rd_idx),
    .rd_valid(rd_valid),
    .rd_err  (rd_err),
    .rd_data (rd_data)
  );

  assign run_enable  = (state_reg == ST_RUN);
  assign done        = (state_reg == ST_DONE);
  assign halt_cause  = halt_cause_reg;
  assign cycle_count = cycle_count_reg;
  assign rd_pc       = rd_data[2*DATA_W-1:DATA_W];
  assign rd_instr    = rd_data[DATA_W-1:0];

endmodule
